// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states and access size codes.
// Imported by the controller and by the lane helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // True when the access size cannot be served at this byte offset.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
        return (size == SZ_ILL) ||
               ((size == SZ_HALF) && offset[0]) ||
               ((size == SZ_WORD) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane handling: extracts and extends the addressed load lane,
// and merges store data into the addressed lane of a full word.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byteLane;
    logic [15:0] w_halfLane;

    always_comb begin
        w_byteLane = i_word[7:0];
        case (i_offset)
            2'd1:    w_byteLane = i_word[15:8];
            2'd2:    w_byteLane = i_word[23:16];
            2'd3:    w_byteLane = i_word[31:24];
            default: w_byteLane = i_word[7:0];
        endcase
        w_halfLane = i_offset[1] ? i_word[31:16] : i_word[15:0];

        // Extension bit is the lane MSB unless the load is unsigned.
        o_load = i_word;
        case (i_size)
            SZ_BYTE: o_load = {{24{~i_uns & w_byteLane[7]}}, w_byteLane};
            SZ_HALF: o_load = {{16{~i_uns & w_halfLane[15]}}, w_halfLane};
            default: o_load = i_word;
        endcase

        o_merged = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_merged = i_word;
                case (i_offset)
                    2'd1:    o_merged[15:8]  = i_wdata[7:0];
                    2'd2:    o_merged[23:16] = i_wdata[7:0];
                    2'd3:    o_merged[31:24] = i_wdata[7:0];
                    default: o_merged[7:0]   = i_wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                o_merged = i_word;
                if (i_offset[1]) o_merged[31:16] = i_wdata[15:0];
                else             o_merged[15:0]  = i_wdata[15:0];
            end
            default: o_merged = i_wdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller between a CPU port and a single-cycle word memory.
// Sub-word stores are done as read-modify-write; illegal requests answer with err.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] LP_MEM_WORDS = 32'(MEM_WORDS);

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_uns;
    logic        r_we;
    logic        r_err;
    logic [31:0] r_word;

    logic        w_accept;
    logic        w_reqErr;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign w_accept = (r_state == IDLE) && req;
    assign w_reqErr = isMisaligned(size, addr[1:0]) || ({2'b00, addr[31:2]} >= LP_MEM_WORDS);

    lsu_lane u_lane (
        .i_word   (r_word),
        .i_wdata  (r_wdata),
        .i_offset (r_addr[1:0]),
        .i_size   (r_size),
        .i_uns    (r_uns),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= '0;
            r_uns   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_word  <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_addr  <= addr;
                r_wdata <= wdata;
                r_size  <= size;
                r_uns   <= uns;
                r_we    <= we;
                r_err   <= w_reqErr;
            end
            if (r_state == RD) begin
                r_word <= mem_rdata;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        busy        = (r_state != IDLE);
        done        = 1'b0;
        err         = 1'b0;
        rdata       = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (r_state)
            IDLE: begin
                // Word stores skip the read; everything else legal reads first.
                if (req) begin
                    if (w_reqErr)                   w_nextState = RESP;
                    else if (we && size == SZ_WORD) w_nextState = WR;
                    else                            w_nextState = RD;
                end
            end
            RD: begin
                mem_read    = 1'b1;
                mem_addr    = {r_addr[31:2], 2'b00};
                w_nextState = r_we ? WR : RESP;
            end
            WR: begin
                mem_write   = 1'b1;
                mem_addr    = {r_addr[31:2], 2'b00};
                mem_wdata   = w_merged;
                w_nextState = RESP;
            end
            RESP: begin
                done        = 1'b1;
                err         = r_err;
                rdata       = (!r_we && !r_err) ? w_load : 32'd0;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: a reference memory model predicts each access,
// and the expected response is compared when the DUT raises done.
module tb_lsu_ctrl;

    localparam int MEM_WORDS = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem    [0:MEM_WORDS-1];
    logic [31:0] refMem [0:MEM_WORDS-1];

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          rd;
        int          wr;
        logic [31:0] wdata;
        logic [31:0] waddr;
    } exp_t;

    exp_t        sb[$];
    int          checkCount = 0;
    int          passCount  = 0;
    logic [31:0] lastRdata;
    logic [31:0] lastWdata;

    lsu_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .size      (size),
        .uns       (uns),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural memory: combinational read, write on the rising edge.
    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checkCount++;
        if (obs === expv) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    endtask

    // Predicts one access from the reference memory and updates it for stores.
    function automatic exp_t modelAccess(input logic w, input logic [1:0] sz, input logic u,
                                         input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        int          sh;
        logic [31:0] word;
        logic [31:0] mask;
        logic [31:0] lane;
        sh      = 8 * int'(a[1:0]);
        e.err   = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) ||
                  ({2'b00, a[31:2]} >= 32'(MEM_WORDS));
        e.rdata = '0;
        e.lat   = 1;
        e.rd    = 0;
        e.wr    = 0;
        e.wdata = '0;
        e.waddr = '0;
        if (!e.err) begin
            word = refMem[a[7:2]];
            mask = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
            if (!w) begin
                lane = (word >> sh) & mask;
                if (!u && sz == 2'b00 && lane[7])  lane = lane | 32'hFFFF_FF00;
                if (!u && sz == 2'b01 && lane[15]) lane = lane | 32'hFFFF_0000;
                e.rdata = lane;
                e.rd    = 1;
                e.lat   = 2;
            end else begin
                e.wdata = (word & ~(mask << sh)) | ((d & mask) << sh);
                e.waddr = {a[31:2], 2'b00};
                e.wr    = 1;
                e.rd    = (sz == 2'b10) ? 0 : 1;
                e.lat   = (sz == 2'b10) ? 2 : 3;
                refMem[a[7:2]] = e.wdata;
            end
        end
        return e;
    endfunction

    // Issues one request; with hold set, req stays high and the inputs are
    // scrambled while the access is in flight.
    task automatic applyStimulus(input string name, input logic w, input logic [1:0] sz,
                                 input logic u, input logic [31:0] a, input logic [31:0] d,
                                 input bit hold);
        exp_t        e;
        int          n;
        int          rdC;
        int          wrC;
        logic [31:0] wa;
        logic [31:0] gotRdata;
        logic        gotErr;
        bit          seen;
        @(negedge clk);
        checkOutput({name, "/idle"}, {30'd0, busy, done}, 32'd0);
        we    = w;
        size  = sz;
        uns   = u;
        addr  = a;
        wdata = d;
        req   = 1'b1;
        sb.push_back(modelAccess(w, sz, u, a, d));
        @(posedge clk);
        #1;
        if (!hold) req = 1'b0;
        rdC      = 0;
        wrC      = 0;
        wa       = '0;
        lastWdata = '0;
        gotRdata = '0;
        gotErr   = 1'b0;
        seen     = 1'b0;
        n        = 0;
        while (!seen && n < 10) begin
            @(negedge clk);
            n++;
            if (mem_read) rdC++;
            if (mem_write) begin
                wrC++;
                lastWdata = mem_wdata;
                wa        = mem_addr;
            end
            if (done) begin
                seen     = 1'b1;
                gotRdata = rdata;
                gotErr   = err;
            end else if (hold) begin
                addr  = 32'($urandom_range(0, 63)) << 2;
                wdata = $urandom;
                size  = 2'($urandom_range(0, 3));
                uns   = 1'($urandom_range(0, 1));
            end
        end
        e         = sb.pop_front();
        lastRdata = gotRdata;
        checkOutput({name, "/done"},    32'(seen), 32'd1);
        checkOutput({name, "/latency"}, 32'(n), 32'(e.lat));
        checkOutput({name, "/err"},     32'(gotErr), 32'(e.err));
        checkOutput({name, "/rdata"},   gotRdata, e.rdata);
        checkOutput({name, "/reads"},   32'(rdC), 32'(e.rd));
        checkOutput({name, "/writes"},  32'(wrC), 32'(e.wr));
        if (e.wr != 0) begin
            checkOutput({name, "/wdata"}, lastWdata, e.wdata);
            checkOutput({name, "/waddr"}, wa, e.waddr);
        end
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "/busy"},      32'(busy), 32'd0);
        checkOutput({name, "/done"},      32'(done), 32'd0);
        checkOutput({name, "/err"},       32'(err), 32'd0);
        checkOutput({name, "/rdata"},     rdata, 32'd0);
        checkOutput({name, "/mem_read"},  32'(mem_read), 32'd0);
        checkOutput({name, "/mem_write"}, 32'(mem_write), 32'd0);
        checkOutput({name, "/mem_addr"},  mem_addr, 32'd0);
        checkOutput({name, "/mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        int diffs;
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i]    = '0;
            refMem[i] = '0;
        end
        rst_n = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        size  = 2'b00;
        uns   = 1'b0;
        addr  = '0;
        wdata = '0;
        #12;
        checkResetOutputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Word store then word load.
        applyStimulus("st_w10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        applyStimulus("ld_w10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        checkOutput("ld_w10/const", lastRdata, 32'hDEADBEEF);

        // Byte store by read-modify-write.
        applyStimulus("st_w20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 1'b0);
        applyStimulus("st_b21", 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, 1'b0);
        checkOutput("st_b21/const", lastWdata, 32'h1122AA44);

        // Load lane extraction and extension.
        applyStimulus("st_w30", 1'b1, 2'b10, 1'b0, 32'h30, 32'h80FF7F01, 1'b0);
        applyStimulus("ld_b32s", 1'b0, 2'b00, 1'b0, 32'h32, 32'h0, 1'b0);
        checkOutput("ld_b32s/const", lastRdata, 32'hFFFFFFFF);
        applyStimulus("ld_b33u", 1'b0, 2'b00, 1'b1, 32'h33, 32'h0, 1'b0);
        checkOutput("ld_b33u/const", lastRdata, 32'h00000080);
        applyStimulus("ld_h30s", 1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 1'b0);
        checkOutput("ld_h30s/const", lastRdata, 32'h00007F01);
        applyStimulus("ld_h32s", 1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 1'b0);
        applyStimulus("ld_h32u", 1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 1'b0);
        applyStimulus("st_h32",  1'b1, 2'b01, 1'b0, 32'h32, 32'hCAFE1234, 1'b0);
        applyStimulus("ld_w30",  1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0);

        // Rejected requests.
        applyStimulus("err_w06",  1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b0);
        applyStimulus("err_h03",  1'b1, 2'b01, 1'b0, 32'h03, 32'h5555, 1'b0);
        applyStimulus("err_sz11", 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1'b0);
        applyStimulus("err_w100", 1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678, 1'b0);

        // Reset during the read phase of a byte store.
        applyStimulus("st_w24", 1'b1, 2'b10, 1'b0, 32'h24, 32'hA5A5A5A5, 1'b0);
        @(negedge clk);
        we    = 1'b1;
        size  = 2'b00;
        uns   = 1'b0;
        addr  = 32'h25;
        wdata = 32'h0000003C;
        req   = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid/in_rd", 32'(mem_read), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("rst_mid");
        repeat (2) @(negedge clk);
        checkOutput("rst_mid/word", mem[9], 32'hA5A5A5A5);
        rst_n = 1'b1;
        applyStimulus("ld_w24", 1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 1'b0);

        // req held high with inputs changing while busy.
        applyStimulus("hold0", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
        applyStimulus("hold1", 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 1'b1);
        applyStimulus("hold2", 1'b1, 2'b00, 1'b0, 32'h2C, 32'h77, 1'b1);
        applyStimulus("hold3", 1'b0, 2'b01, 1'b0, 32'h2C, 32'h0, 1'b1);
        req = 1'b0;

        // Mixed random traffic, including out-of-range and illegal sizes.
        for (int k = 0; k < 12; k++) begin
            applyStimulus("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 32'($urandom_range(0, 271)), $urandom, 1'b0);
        end

        @(negedge clk);
        diffs = 0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            if (mem[i] !== refMem[i]) diffs++;
        end
        checkOutput("mem_final", 32'(diffs), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64, meaning the number of 32-bit words in the attached data memory.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port req, input, 1, CPU access request; sampled only in IDLE.
REQ-005 SHALL have port we, input, 1, 1 = store, 0 = load.
REQ-006 SHALL have port size, input, 2, access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 SHALL have port uns, input, 1, 1 = zero-extend loads, 0 = sign-extend.
REQ-008 SHALL have port addr, input, 32, CPU byte address.
REQ-009 SHALL have port wdata, input, 32, store data, right-aligned: byte in [7:0], halfword in [15:0].
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port err, output, 1, valid with done: request rejected, no memory access made.
REQ-013 SHALL have port rdata, output, 32, extended load result; valid with done.
REQ-014 SHALL have port mem_read, output, 1, memory read enable.
REQ-015 SHALL have port mem_write, output, 1, memory write enable; the memory writes on the rising clk edge.
REQ-016 SHALL have port mem_addr, output, 32, word-aligned byte address {addr[31:2],2'b00}.
REQ-017 SHALL have port mem_wdata, output, 32, merged full word for writing.
REQ-018 SHALL have port mem_rdata, input, 32, memory read data; combinational, valid in the same cycle mem_read is high.

Function
REQ-019 SHALL implement the FSM states IDLE, RD, WR and RESP.
REQ-020 SHALL, when req=1 in IDLE, register addr, wdata, size, uns and we at that edge; later input changes SHALL NOT affect the access.
REQ-021 SHALL route an accepted request to RESP with err=1, making no memory access, if any of these hold: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=0; addr[31:2] >= MEM_WORDS.
REQ-022 SHALL follow these transitions for legal requests:
- load: IDLE->RD->RESP
- word store: IDLE->WR->RESP
- byte or halfword store: IDLE->RD->WR->RESP (read-modify-write).
REQ-023 SHALL go from RESP to IDLE unconditionally; req SHALL be ignored in RD, WR and RESP, so back-to-back requests are accepted no earlier than the cycle after done.
REQ-024 SHALL, in RD, assert mem_read=1 and capture mem_rdata into an internal word register at the end of the cycle.
REQ-025 SHALL, in WR, assert mem_write=1 and drive mem_wdata:
- word store: the captured wdata
- sub-word store: the captured word with only the addressed byte lane (little-endian: offset 0 = [7:0]) or halfword lane (offset 0 = [15:0], offset 2 = [31:16]) replaced.
REQ-026 SHALL hold mem_read, mem_write, mem_addr and mem_wdata at 0 outside RD and WR.
REQ-027 SHALL, in RESP, drive done=1 and, for loads, rdata = the addressed lane sign- or zero-extended per uns; for stores and errors rdata=0.
REQ-028 SHALL have latencies from the accept edge to done high of: load 2 cycles, word store 2, sub-word store 3, error 1.

Reset
REQ-029 SHALL, on rst_n=0, immediately enter IDLE, regardless of clk or current state.
REQ-030 SHALL, during reset, force to 0: busy, done, err, rdata, mem_read, mem_write, mem_addr, mem_wdata and all captured registers.
REQ-031 SHALL, if reset occurs mid-access, abandon that access: it never completes and no write occurs after reset assertion.

Structure
REQ-032 SHALL take the state encoding and the size codes (SZ_BYTE, SZ_HALF, SZ_WORD) from the shared package lsu_pkg.
REQ-033 SHALL place lane extraction/extension and lane merge in one combinational sub-module, lsu_lane.

Verification
REQ-034 SHALL verify a word store then load: store 0xDEADBEEF at 0x10, then load a word from 0x10 -> mem_write for one cycle at mem_addr 0x10; load gives done 2 cycles after accept, rdata=0xDEADBEEF, err=0.
REQ-035 SHALL verify a byte store via read-modify-write: word 0x11223344 at 0x20, then store byte 0xAA at 0x21 -> RD then WR; mem_wdata=0x1122AA44; done 3 cycles after accept.
REQ-036 SHALL verify load extension: word 0x80FF7F01 at 0x30 gives:
- byte at 0x32, uns=0 -> 0xFFFFFFFF
- byte at 0x33, uns=1 -> 0x00000080
- halfword at 0x30, uns=0 -> 0x00007F01.
REQ-037 SHALL verify errors: word at 0x06, halfword at 0x03, size=11, and word at 0x100 (MEM_WORDS=64) -> each gives err=1, done 1 cycle after accept, mem_read and mem_write never asserted.
REQ-038 SHALL verify reset mid-write: assert rst_n=0 in the RD cycle of a byte store -> the outputs of REQ-030 go 0 immediately, the word is unchanged, and the next req is accepted normally.
REQ-039 SHALL verify request hold-off: hold req=1 with changing addr during busy -> exactly one access per done, and each access uses the address sampled at its accept edge.
